// File: rtl/m_btn_filter_v20_if.sv
// Button filter bus: raw button inputs toward the filter, and the clean
// levels plus event pulses back toward the control FSMs.
interface m_btn_filter_v20_if #(
  parameter int N = 4
);
  logic [N-1:0] BTN_I;
  logic [N-1:0] BTN_O;
  logic [N-1:0] BTN_PRESS;
  logic [N-1:0] BTN_RELEASE;
  logic [N-1:0] BTN_REPEAT;
  logic         ANY_PRESS;

  // Side that owns the raw buttons and consumes the filtered events
  modport master (
    output BTN_I,
    input  BTN_O,
    input  BTN_PRESS,
    input  BTN_RELEASE,
    input  BTN_REPEAT,
    input  ANY_PRESS
  );

  // The filter itself
  modport slave (
    input  BTN_I,
    output BTN_O,
    output BTN_PRESS,
    output BTN_RELEASE,
    output BTN_REPEAT,
    output ANY_PRESS
  );
endinterface

// File: rtl/m_btn_filter_v20.sv
// Multi-channel button debouncer with press/release/auto-repeat pulses.
//
// Repeat FSM, one per channel:
//   state     | meaning
//   ST_IDLE   | key released (or just reset), no repeat timing running
//   ST_DELAY  | key held, counting the initial delay to the first repeat
//   ST_REPEAT | key held, emitting a repeat every REP_PERIOD CE ticks
//
// A level change commits only on the CE tick that completes 2^CNT_W
// consecutive ticks of disagreement; any agreement in between restarts
// the count. All pulse outputs are registered and one CLK wide.
module m_btn_filter_v20 #(
  parameter int N          = 4,
  parameter int CNT_W      = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int REPEAT_EN  = 1,
  parameter int REP_DELAY  = 200,
  parameter int REP_PERIOD = 50
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE,
  m_btn_filter_v20_if.slave       bus
);

  localparam int R_MAX  = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RCNT_W = (R_MAX > 1) ? $clog2(R_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST    = '1;
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REP_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [N-1:0] btn_in;
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] press_ev;
  logic [N-1:0] rel_ev;
  logic         any_q;

  // Normalise polarity so a pressed key is always 1 inside the block;
  // reset value 0 of the synchroniser then means "released".
  assign btn_in = (ACTIVE_LOW != 0) ? ~bus.BTN_I : bus.BTN_I;

  // Two-flop synchroniser for every raw input
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // ANY_PRESS is registered alongside the per-channel press pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |press_ev;
    end
  end

  assign bus.ANY_PRESS = any_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             press_q;
    logic             rel_q;

    // Commit events: the tick that completes the disagreement window
    assign press_ev[g] = CE && (cnt == CNT_LAST) &&  sync2[g] && !lvl_q;
    assign rel_ev[g]   = CE && (cnt == CNT_LAST) && !sync2[g] &&  lvl_q;

    // Debounce counter, committed level and edge pulses
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= press_ev[g];
        rel_q   <= rel_ev[g];
        if (sync2[g] == lvl_q) begin
          cnt <= '0;
        end else if (CE) begin
          if (cnt == CNT_LAST) begin
            lvl_q <= sync2[g];
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end

    assign bus.BTN_O[g]       = lvl_q;
    assign bus.BTN_PRESS[g]   = press_q;
    assign bus.BTN_RELEASE[g] = rel_q;

    if (REPEAT_EN != 0) begin : g_rep
      rep_state_t        st;
      logic [RCNT_W-1:0] rcnt;
      logic              rep_q;

      // Auto-repeat FSM; a release commit always beats a due repeat
      always_ff @(posedge CLK) begin
        if (RST) begin
          st    <= ST_IDLE;
          rcnt  <= '0;
          rep_q <= 1'b0;
        end else begin
          rep_q <= 1'b0;
          case (st)
            ST_IDLE: begin
              if (press_ev[g]) begin
                st   <= ST_DELAY;
                rcnt <= '0;
              end
            end
            ST_DELAY: begin
              if (rel_ev[g]) begin
                st <= ST_IDLE;
              end else if (CE) begin
                if (rcnt == DELAY_LAST) begin
                  rep_q <= 1'b1;
                  rcnt  <= '0;
                  st    <= ST_REPEAT;
                end else begin
                  rcnt <= rcnt + RCNT_W'(1);
                end
              end
            end
            ST_REPEAT: begin
              if (rel_ev[g]) begin
                st <= ST_IDLE;
              end else if (CE) begin
                if (rcnt == PERIOD_LAST) begin
                  rep_q <= 1'b1;
                  rcnt  <= '0;
                end else begin
                  rcnt <= rcnt + RCNT_W'(1);
                end
              end
            end
            default: begin
              st   <= ST_IDLE;
              rcnt <= '0;
            end
          endcase
        end
      end

      assign bus.BTN_REPEAT[g] = rep_q;
    end else begin : g_norep
      assign bus.BTN_REPEAT[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_m_btn_filter_v20.sv
// Bench for m_btn_filter_v20: an active-high and an active-low instance
// see the same logical stimulus and are compared against a tick-counting
// reference model every cycle, plus fixed edge-number expectations.
module tb_m_btn_filter_v20;
  localparam int N          = 4;
  localparam int CNT_W      = 4;
  localparam int REP_DELAY  = 8;
  localparam int REP_PERIOD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic [N-1:0] btn_log;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m_btn_filter_v20_if #(.N(N)) if_a ();
  m_btn_filter_v20_if #(.N(N)) if_b ();

  assign if_a.BTN_I = btn_log;
  assign if_b.BTN_I = ~btn_log;

  m_btn_filter_v20 #(
    .N(N), .CNT_W(CNT_W), .ACTIVE_LOW(0), .REPEAT_EN(1),
    .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) dut_a (
    .CLK(clk), .RST(rst), .CE(ce), .bus(if_a)
  );

  m_btn_filter_v20 #(
    .N(N), .CNT_W(CNT_W), .ACTIVE_LOW(1), .REPEAT_EN(1),
    .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) dut_b (
    .CLK(clk), .RST(rst), .CE(ce), .bus(if_b)
  );

  // Reference model: counts disagreement ticks and ticks held since press
  logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rep;
  logic         m_any;
  int           m_dis  [N];
  int           m_held [N];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_dis[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        m_rep[i]   = 1'b0;
        if (m_s2[i] == m_lvl[i]) begin
          m_dis[i] = 0;
        end else if (ce) begin
          m_dis[i] = m_dis[i] + 1;
          if (m_dis[i] == (1 << CNT_W)) begin
            m_lvl[i] = m_s2[i];
            m_dis[i] = 0;
            if (m_lvl[i]) begin
              m_press[i] = 1'b1;
              m_held[i]  = 0;
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end
        if (m_lvl[i] && !m_press[i] && ce) begin
          m_held[i] = m_held[i] + 1;
          if (m_held[i] >= REP_DELAY &&
              ((m_held[i] - REP_DELAY) % REP_PERIOD) == 0)
            m_rep[i] = 1'b1;
        end
      end
      m_any = |m_press;
      m_s2  = m_s1;
      m_s1  = btn_log;
    end
  end

  wire [4*N:0] obs_a = {if_a.BTN_O, if_a.BTN_PRESS, if_a.BTN_RELEASE,
                        if_a.BTN_REPEAT, if_a.ANY_PRESS};
  wire [4*N:0] obs_b = {if_b.BTN_O, if_b.BTN_PRESS, if_b.BTN_RELEASE,
                        if_b.BTN_REPEAT, if_b.ANY_PRESS};
  wire [4*N:0] exp_m = {m_lvl, m_press, m_rel, m_rep, m_any};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ce      = 1'b1;
    btn_log = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    ce      = 1'b1;
    btn_log = 4'b1111;
    tick();
    n_checks++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs a=%h b=%h expected 0", obs_a, obs_b);
    end
    tick();
    btn_log = '0;
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL reset_idle e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
    end
  endtask

  task automatic test_press();
    int press_edge = -1;
    int press_cnt  = 0;
    do_reset();
    btn_log = 4'b0001;
    for (int e = 1; e <= 40; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL press_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_PRESS[0] === 1'b1) begin
        press_cnt++;
        if (press_edge < 0) press_edge = e;
      end
    end
    n_checks++;
    if (press_edge != 18 || press_cnt != 1) begin
      n_fail++;
      $display("FAIL press_edge edge=%0d count=%0d expected edge 18 count 1", press_edge, press_cnt);
    end
    n_checks++;
    if (if_a.BTN_O !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_level got=%b expected 0001", if_a.BTN_O);
    end
  endtask

  task automatic test_glitch();
    int press_edge = -1;
    int ev_cnt     = 0;
    do_reset();
    btn_log = 4'b0010;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11) btn_log = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL glitch_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_O[1] || if_a.BTN_PRESS[1] || if_a.BTN_RELEASE[1]) ev_cnt++;
    end
    n_checks++;
    if (ev_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_quiet active_cycles=%0d expected 0", ev_cnt);
    end
    // 12 cycles high, one-cycle dropout, then high again
    btn_log = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL dropout_pre e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
    end
    btn_log = 4'b0000;
    tick();
    btn_log = 4'b0010;
    for (int e = 1; e <= 24; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL dropout_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_PRESS[1] === 1'b1 && press_edge < 0) press_edge = e;
    end
    n_checks++;
    if (press_edge != 18) begin
      n_fail++;
      $display("FAIL dropout_edge got=%0d expected 18", press_edge);
    end
  endtask

  task automatic test_repeat();
    int rep_q[$];
    int exp_rep[6] = '{26, 30, 34, 38, 42, 46};
    int press_edge = -1;
    int rel_edge   = -1;
    do_reset();
    btn_log = 4'b0100;
    for (int e = 1; e <= 70; e++) begin
      if (e == 33) btn_log = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL repeat_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_PRESS[2] === 1'b1) press_edge = e;
      if (if_a.BTN_RELEASE[2] === 1'b1) rel_edge = e;
      if (if_a.BTN_REPEAT[2] === 1'b1) rep_q.push_back(e);
    end
    n_checks++;
    if (press_edge != 18 || rel_edge != 50) begin
      n_fail++;
      $display("FAIL repeat_edges press=%0d release=%0d expected 18 and 50", press_edge, rel_edge);
    end
    n_checks++;
    if (rep_q.size() != 6) begin
      n_fail++;
      $display("FAIL repeat_count got=%0d expected 6", rep_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (rep_q[k] != exp_rep[k]) begin
          n_fail++;
          $display("FAIL repeat_pos k=%0d got=%0d expected %0d", k, rep_q[k], exp_rep[k]);
        end
      end
    end
  endtask

  task automatic test_slow_ce();
    int press_edge = -1;
    int press_cnt  = 0;
    do_reset();
    btn_log = 4'b1000;
    for (int e = 1; e <= 80; e++) begin
      ce = ((e % 4) == 0);
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL slowce_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_PRESS[3] === 1'b1) begin
        press_cnt++;
        if (press_edge < 0) press_edge = e;
      end
    end
    ce = 1'b1;
    n_checks++;
    if (press_edge != 64 || press_cnt != 1) begin
      n_fail++;
      $display("FAIL slowce_press edge=%0d count=%0d expected edge 64 count 1", press_edge, press_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int press_edge = -1;
    do_reset();
    btn_log = 4'b0001;
    for (int e = 1; e <= 20; e++) tick();
    n_checks++;
    if (if_a.BTN_O[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got=%b expected 1", if_a.BTN_O[0]);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear a=%h b=%h expected 0", obs_a, obs_b);
    end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL midrst_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.BTN_PRESS[0] === 1'b1 && press_edge < 0) press_edge = e;
    end
    n_checks++;
    if (press_edge != 18) begin
      n_fail++;
      $display("FAIL midrst_press got=%0d expected 18", press_edge);
    end
  endtask

  task automatic test_simultaneous();
    int any_edge = -1;
    int any_cnt  = 0;
    int both_ok  = 0;
    do_reset();
    btn_log = 4'b1001;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL simul_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
      if (if_a.ANY_PRESS === 1'b1) begin
        any_cnt++;
        any_edge = e;
        if (if_a.BTN_PRESS === 4'b1001 && if_b.BTN_PRESS === 4'b1001 &&
            if_b.ANY_PRESS === 1'b1) both_ok = 1;
      end
    end
    n_checks++;
    if (any_edge != 18 || any_cnt != 1 || both_ok != 1) begin
      n_fail++;
      $display("FAIL simul_press any_edge=%0d any_cnt=%0d both=%0d expected 18 1 1", any_edge, any_cnt, both_ok);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] target = '0;
    int bounce [N];
    for (int i = 0; i < N; i++) bounce[i] = 0;
    do_reset();
    for (int e = 1; e <= 3000; e++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 59) == 0) begin
          target[i] = ~target[i];
          bounce[i] = $urandom_range(0, 12);
        end
        if (bounce[i] > 0) begin
          btn_log[i] = 1'($urandom_range(0, 1));
          bounce[i]--;
        end else begin
          btn_log[i] = target[i];
        end
      end
      ce = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (obs_a !== exp_m || obs_b !== exp_m) begin
        n_fail++;
        $display("FAIL random_model e=%0d a=%h b=%h expected %h", e, obs_a, obs_b, exp_m);
      end
    end
    ce = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b1;
    btn_log = '0;
    test_reset();
    test_press();
    test_glitch();
    test_repeat();
    test_slow_ce();
    test_mid_reset();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
